// File: rtl/counter_pkg.sv
// Shared types for the counter command sequencer: FSM encoding and the
// {preset, run-length} command word carried through the command FIFO.
package counter_pkg;
  localparam int CNT_WIDTH = 8;
  localparam int CNT_LEN_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] preset;
    logic [CNT_LEN_W-1:0] len;
  } seq_cmd_t;

  // An up-counter only moves backwards when it rolls over.
  function automatic logic count_wrapped(input logic [CNT_WIDTH-1:0] cur,
                                         input logic [CNT_WIDTH-1:0] prev);
    return cur < prev;
  endfunction
endpackage

// File: rtl/counter_load_sequencer_fifo.sv
// First-word fall-through command FIFO; the extra pointer bit separates
// full from empty when the index bits match.
module seq_cmd_fifo
  import counter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  seq_cmd_t din,
  output seq_cmd_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  seq_cmd_t      mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/counter_load_sequencer.sv
// Plays buffered {preset, len} commands into the even up-counter as one load
// cycle plus len enable cycles, then reports final count, wrap and load check.
module counter_load_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH      = CNT_WIDTH,
  parameter int LEN_W      = CNT_LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_preset,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             load,
  output logic             enable,
  output logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] done_count,
  output logic             wrapped,
  output logic             load_err
);
  seq_cmd_t   cmd_in, head;
  logic       fifo_full, fifo_empty, pop;

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] cur_preset_q, cur_preset_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] prev_cnt_q, prev_cnt_d;
  logic             wrap_acc_q, wrap_acc_d;
  logic             load_q, load_d;
  logic             enable_q, enable_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] done_count_q, done_count_d;
  logic             wrapped_q, wrapped_d;
  logic             load_err_q, load_err_d;

  assign cmd_in    = '{preset: cmd_preset, len: cmd_len};
  assign cmd_ready = !fifo_full;

  seq_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cur_preset_d = cur_preset_q;
    cur_len_d    = cur_len_q;
    remaining_d  = remaining_q;
    prev_cnt_d   = prev_cnt_q;
    wrap_acc_d   = wrap_acc_q;
    done_d       = 1'b0;
    done_count_d = done_count_q;
    wrapped_d    = wrapped_q;
    load_err_d   = load_err_q;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          cur_preset_d = head.preset;
          cur_len_d    = head.len;
          state_d      = LOAD;
        end
      end
      LOAD: state_d = CHECK;
      CHECK: begin
        if (q != cur_preset_q) load_err_d = 1'b1;
        prev_cnt_d  = q;
        remaining_d = cur_len_q;
        wrap_acc_d  = 1'b0;
        state_d     = (cur_len_q == '0) ? DONE : RUN;
      end
      RUN: begin
        wrap_acc_d  = wrap_acc_q | count_wrapped(q, prev_cnt_q);
        prev_cnt_d  = q;
        remaining_d = remaining_q - LEN_W'(1);
        if (remaining_q == LEN_W'(1)) state_d = DONE;
      end
      DONE: begin
        // q already carries the last increment here, so the final step's wrap is folded in.
        done_d       = 1'b1;
        done_count_d = q;
        wrapped_d    = wrap_acc_q | count_wrapped(q, prev_cnt_q);
        if (!fifo_empty) begin
          pop          = 1'b1;
          cur_preset_d = head.preset;
          cur_len_d    = head.len;
          state_d      = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter-facing outputs are decoded from the next state so they line up with it.
    load_d   = (state_d == LOAD);
    enable_d = (state_d == RUN);
    d_d      = pop ? head.preset : d_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_preset_q <= '0;
      cur_len_q    <= '0;
      remaining_q  <= '0;
      prev_cnt_q   <= '0;
      wrap_acc_q   <= 1'b0;
      load_q       <= 1'b0;
      enable_q     <= 1'b0;
      d_q          <= '0;
      done_q       <= 1'b0;
      done_count_q <= '0;
      wrapped_q    <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      cur_preset_q <= cur_preset_d;
      cur_len_q    <= cur_len_d;
      remaining_q  <= remaining_d;
      prev_cnt_q   <= prev_cnt_d;
      wrap_acc_q   <= wrap_acc_d;
      load_q       <= load_d;
      enable_q     <= enable_d;
      d_q          <= d_d;
      done_q       <= done_d;
      done_count_q <= done_count_d;
      wrapped_q    <= wrapped_d;
      load_err_q   <= load_err_d;
    end
  end

  assign load       = load_q;
  assign enable     = enable_q;
  assign d          = d_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign done       = done_q;
  assign done_count = done_count_q;
  assign wrapped    = wrapped_q;
  assign load_err   = load_err_q;
endmodule

// File: tb/tb_counter_load_sequencer.sv
// Sequencer driving a behavioural even up-counter; completed commands are
// scored against (preset + 2*len) mod 256 and a >=256 wrap rule.
module tb_counter_load_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_preset;
  logic [7:0] cmd_len;
  logic       load, enable;
  logic [7:0] d;
  logic [7:0] q;
  logic       busy, done, wrapped, load_err;
  logic [7:0] done_count;
  logic       stuck = 1'b0;

  int checks = 0;
  int failures = 0;

  counter_load_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_preset(cmd_preset), .cmd_len(cmd_len), .load(load), .enable(enable),
    .d(d), .q(q), .busy(busy), .done(done), .done_count(done_count),
    .wrapped(wrapped), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Even up-counter; 'stuck' freezes it to emulate a broken load path.
  always @(posedge clk or posedge reset) begin
    if (reset) q <= 8'd0;
    else if (!stuck) begin
      if (load)        q <= d;
      else if (enable) q <= q + 8'd2;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: only this block writes the observation state.
  int obs_cnt[$];
  bit obs_wrap[$];
  int load_cycles = 0, enable_cycles = 0, overlap = 0, last_load_cyc = 0;
  logic [7:0] last_load_d = 8'd0;
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        obs_cnt.push_back(int'(done_count));
        obs_wrap.push_back(wrapped);
      end
      if (load) begin
        load_cycles   <= load_cycles + 1;
        last_load_d   <= d;
        last_load_cyc <= cyc;
      end
      if (enable)         enable_cycles <= enable_cycles + 1;
      if (load && enable) overlap <= overlap + 1;
    end
  end

  int exp_cnt[$];
  bit exp_wrap[$];
  int obs_rd = 0;

  task automatic send(input logic [7:0] p, input logic [7:0] l);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_preset = p; cmd_len = l;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    if (cmd_ready) begin
      @(posedge clk);
      exp_cnt.push_back((int'(p) + 2 * int'(l)) % 256);
      exp_wrap.push_back((int'(p) + 2 * int'(l)) >= 256);
      #1;
    end else begin
      checks++; failures++;
      $display("FAIL send_timeout: cmd_ready got 0 expected 1 within 1000 cycles");
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_dones(input int n, output bit ok);
    int b = 0;
    while (obs_cnt.size() < obs_rd + n && b < 3000) begin @(negedge clk); #1; b++; end
    ok = (obs_cnt.size() >= obs_rd + n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0; stuck = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_cnt.delete(); exp_wrap.delete();
    #1 obs_rd = obs_cnt.size();
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_preset = 8'd0; cmd_len = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (load !== 1'b0)   begin failures++; $display("FAIL rst_load: got %b expected 0", load); end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL rst_enable: got %b expected 0", enable); end
    checks++; if (d !== 8'd0)      begin failures++; $display("FAIL rst_d: got %0d expected 0", d); end
    checks++; if (done !== 1'b0)   begin failures++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (done_count !== 8'd0) begin failures++; $display("FAIL rst_done_count: got %0d expected 0", done_count); end
    checks++; if (wrapped !== 1'b0 || load_err !== 1'b0) begin failures++; $display("FAIL rst_flags: got wrapped=%b load_err=%b expected 0 0", wrapped, load_err); end
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int base = enable_cycles;
    int b = 0;
    send(8'd160, 8'd10);
    while (enable_cycles - base < 4 && b < 100) begin @(negedge clk); #1; b++; end
    checks++; if (enable_cycles - base != 4) begin failures++; $display("FAIL midrun_reach: got %0d enables expected 4", enable_cycles - base); end
    reset = 1'b1;
    #1;
    checks++; if (enable !== 1'b0 || load !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL midrun_async_drop: got load=%b enable=%b done=%b expected 0 0 0", load, enable, done); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midrun_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL midrun_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    exp_cnt.delete(); exp_wrap.delete();
    #1 obs_rd = obs_cnt.size();
  endtask

  task automatic test_single();
    int lb = load_cycles;
    int eb = enable_cycles;
    bit ok;
    send(8'd160, 8'd5);
    wait_dones(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_done: got no done expected 1 done"); end
    checks++; if (load_cycles - lb != 1) begin failures++; $display("FAIL single_load_width: got %0d expected 1", load_cycles - lb); end
    checks++; if (last_load_d !== 8'd160) begin failures++; $display("FAIL single_load_d: got %0d expected 160", last_load_d); end
    checks++; if (enable_cycles - eb != 5) begin failures++; $display("FAIL single_enables: got %0d expected 5", enable_cycles - eb); end
    if (ok) begin
      checks++; if (obs_cnt[obs_rd] !== exp_cnt[0]) begin failures++; $display("FAIL single_count: got %0d expected %0d", obs_cnt[obs_rd], exp_cnt[0]); end
      checks++; if (obs_wrap[obs_rd] !== exp_wrap[0]) begin failures++; $display("FAIL single_wrapped: got %b expected %b", obs_wrap[obs_rd], exp_wrap[0]); end
      void'(exp_cnt.pop_front()); void'(exp_wrap.pop_front()); obs_rd++;
    end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL single_load_err: got %b expected 0", load_err); end
  endtask

  task automatic test_wrap();
    int eb;
    bit ok;
    send(8'd250, 8'd3);
    wait_dones(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_done: got no done expected 1 done"); end
    if (ok) begin
      checks++; if (obs_cnt[obs_rd] !== exp_cnt[0] || obs_wrap[obs_rd] !== exp_wrap[0]) begin
        failures++; $display("FAIL wrap_250_3: got count=%0d wrap=%b expected count=%0d wrap=%b", obs_cnt[obs_rd], obs_wrap[obs_rd], exp_cnt[0], exp_wrap[0]); end
      void'(exp_cnt.pop_front()); void'(exp_wrap.pop_front()); obs_rd++;
    end
    eb = enable_cycles;
    send(8'd0, 8'd0);
    wait_dones(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_len_done: got no done expected 1 done"); end
    checks++; if (enable_cycles != eb) begin failures++; $display("FAIL zero_len_enables: got %0d expected 0", enable_cycles - eb); end
    if (ok) begin
      checks++; if (obs_cnt[obs_rd] !== exp_cnt[0] || obs_wrap[obs_rd] !== exp_wrap[0]) begin
        failures++; $display("FAIL zero_len: got count=%0d wrap=%b expected count=%0d wrap=%b", obs_cnt[obs_rd], obs_wrap[obs_rd], exp_cnt[0], exp_wrap[0]); end
      void'(exp_cnt.pop_front()); void'(exp_wrap.pop_front()); obs_rd++;
    end
  endtask

  task automatic test_back_to_back();
    int ob = overlap;
    bit ok;
    send(8'($urandom_range(255)), 8'd40);
    for (int i = 0; i < 4; i++) send(8'($urandom_range(255)), 8'($urandom_range(6)));
    @(negedge clk); #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_full: cmd_ready got %b expected 0", cmd_ready); end
    checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    wait_dones(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done_count: got %0d expected 5", obs_cnt.size() - obs_rd); end
    for (int i = 0; i < 5 && obs_rd < obs_cnt.size() && exp_cnt.size() > 0; i++) begin
      checks++; if (obs_cnt[obs_rd] !== exp_cnt[0] || obs_wrap[obs_rd] !== exp_wrap[0]) begin
        failures++; $display("FAIL b2b_cmd%0d: got count=%0d wrap=%b expected count=%0d wrap=%b", i, obs_cnt[obs_rd], obs_wrap[obs_rd], exp_cnt[0], exp_wrap[0]); end
      void'(exp_cnt.pop_front()); void'(exp_wrap.pop_front()); obs_rd++;
    end
    checks++; if (overlap != ob) begin failures++; $display("FAIL b2b_overlap: got %0d expected 0", overlap - ob); end
  endtask

  task automatic test_load_err();
    bit ok;
    do_reset();
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL lerr_initial: got %b expected 0", load_err); end
    stuck = 1'b1;
    send(8'd64, 8'd2);
    wait_dones(1, ok);
    stuck = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL lerr_done: got no done expected 1 done"); end
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL lerr_set: got %b expected 1", load_err); end
    if (ok) begin void'(exp_cnt.pop_front()); void'(exp_wrap.pop_front()); obs_rd++; end
    send(8'd10, 8'd4);
    send(8'd200, 8'd30);
    wait_dones(2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL lerr_good_done: got %0d expected 2", obs_cnt.size() - obs_rd); end
    for (int i = 0; i < 2 && obs_rd < obs_cnt.size() && exp_cnt.size() > 0; i++) begin
      checks++; if (obs_cnt[obs_rd] !== exp_cnt[0] || obs_wrap[obs_rd] !== exp_wrap[0]) begin
        failures++; $display("FAIL lerr_good%0d: got count=%0d wrap=%b expected count=%0d wrap=%b", i, obs_cnt[obs_rd], obs_wrap[obs_rd], exp_cnt[0], exp_wrap[0]); end
      void'(exp_cnt.pop_front()); void'(exp_wrap.pop_front()); obs_rd++;
    end
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL lerr_sticky: got %b expected 1", load_err); end
    do_reset();
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL lerr_cleared: got %b expected 0", load_err); end
  endtask

  task automatic test_push_pop_same();
    int lb = load_cycles;
    int b = 0;
    int l0;
    bit ok;
    logic [7:0] pb;
    pb = 8'($urandom_range(255));
    send(8'd30, 8'd8);
    while (load_cycles == lb && b < 50) begin @(negedge clk); #1; b++; end
    l0 = last_load_cyc;
    send(pb, 8'd2);
    while (cyc < l0 + 9 && b < 100) begin @(negedge clk); #1; b++; end
    send(8'd100, 8'd1);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL pp_ready: got %b expected 1", cmd_ready); end
    @(negedge clk); #1;
    checks++; if (load !== 1'b1 || d !== pb) begin
      failures++; $display("FAIL pp_direct_load: got load=%b d=%0d expected load=1 d=%0d", load, d, pb); end
    wait_dones(3, ok);
    repeat (20) @(negedge clk);
    #1;
    checks++; if (obs_cnt.size() - obs_rd != 3) begin failures++; $display("FAIL pp_done_total: got %0d expected 3", obs_cnt.size() - obs_rd); end
    for (int i = 0; i < 3 && obs_rd < obs_cnt.size() && exp_cnt.size() > 0; i++) begin
      checks++; if (obs_cnt[obs_rd] !== exp_cnt[0]) begin
        failures++; $display("FAIL pp_seq%0d: got %0d expected %0d", i, obs_cnt[obs_rd], exp_cnt[0]); end
      void'(exp_cnt.pop_front()); void'(exp_wrap.pop_front()); obs_rd++;
    end
  endtask

  task automatic test_random();
    int ob = overlap;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(3)) @(negedge clk);
      send(8'($urandom_range(255)), 8'($urandom_range(12)));
    end
    wait_dones(16, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rand_done_count: got %0d expected 16", obs_cnt.size() - obs_rd); end
    for (int i = 0; i < 16 && obs_rd < obs_cnt.size() && exp_cnt.size() > 0; i++) begin
      checks++; if (obs_cnt[obs_rd] !== exp_cnt[0] || obs_wrap[obs_rd] !== exp_wrap[0]) begin
        failures++; $display("FAIL rand_cmd%0d: got count=%0d wrap=%b expected count=%0d wrap=%b", i, obs_cnt[obs_rd], obs_wrap[obs_rd], exp_cnt[0], exp_wrap[0]); end
      void'(exp_cnt.pop_front()); void'(exp_wrap.pop_front()); obs_rd++;
    end
    checks++; if (overlap != ob) begin failures++; $display("FAIL rand_overlap: got %0d expected 0", overlap - ob); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_single();
    test_wrap();
    test_back_to_back();
    test_load_err();
    test_push_pop_same();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
